// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter feeding the UART TX FIFO push port
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_req0_valid,
  input  logic [7:0]       i_req0_data,
  input  logic             i_req0_last,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [7:0]       i_req1_data,
  input  logic             i_req1_last,
  output logic             o_req1_ready,
  output logic [7:0]       o_tx,
  output logic             o_tx_push,
  input  logic [CNT_W-1:0] i_tx_fifo_cnt,
  output logic             o_owner,
  output logic             o_locked,
  output logic             o_lock_timeout
);
  typedef enum logic [1:0] {IDLE, LOCKED, SETTLE} state_t;
  state_t state, state_nxt;
  logic rr, last_r, space, sel, own_v, xfer, to_hit;
  logic [7:0] tcnt;
  assign space = 32'(i_tx_fifo_cnt) < FIFO_DEPTH;
  assign sel   = (i_req0_valid & i_req1_valid) ? rr : i_req1_valid;
  assign own_v = o_owner ? i_req1_valid : i_req0_valid;
  assign xfer  = o_req0_ready | o_req1_ready;
  // Grant decode: fresh round-robin pick in IDLE, owner-only in LOCKED, nobody while the FIFO count settles
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    to_hit       = 1'b0;
    state_nxt    = state;
    case (state)
      IDLE: begin
        o_req0_ready = i_en & space & i_req0_valid & ~sel;
        o_req1_ready = i_en & space & i_req1_valid & sel;
      end
      LOCKED: begin
        o_req0_ready = ~o_owner & i_req0_valid & space;
        o_req1_ready = o_owner & i_req1_valid & space;
        to_hit       = ~own_v & (tcnt + 8'd1 == 8'(LOCK_TIMEOUT));
      end
      default: ;
    endcase
    state_nxt = xfer ? SETTLE : (state == SETTLE) ? (last_r ? IDLE : LOCKED) : to_hit ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // Push strobe, byte capture, lock flag, round-robin pointer and idle-owner timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tx           <= 8'd0;
      o_tx_push      <= 1'b0;
      o_owner        <= 1'b0;
      o_locked       <= 1'b0;
      o_lock_timeout <= 1'b0;
      rr             <= 1'b0;
      last_r         <= 1'b0;
      tcnt           <= 8'd0;
    end else begin
      o_tx_push      <= xfer;
      o_lock_timeout <= to_hit;
      if (xfer) begin
        o_tx    <= o_req1_ready ? i_req1_data : i_req0_data;
        o_owner <= o_req1_ready;
        last_r  <= o_req1_ready ? i_req1_last : i_req0_last;
        tcnt    <= 8'd0;
      end
      if (state == SETTLE) begin
        o_locked <= ~last_r;
        tcnt     <= 8'd0;
        if (last_r) rr <= ~o_owner;
      end
      if (state == LOCKED && !own_v) tcnt <= to_hit ? 8'd0 : tcnt + 8'd1;
      if (to_hit) begin
        o_locked <= 1'b0;
        rr       <= ~o_owner;
      end
    end
  end
endmodule
